k12a_uart_io: RTL and testbench
===============================

Name: k12a_uart_io

Overview:
I/O-bus responder for the k12a core. It sits on the I/O strobes (io_load_n/io_store_n, port select from inst[2:0]) that the core FSM drives during the EXEC state of in/out instructions. It implements a byte-wide 8N1 UART with TX/RX FIFOs, status/control registers, and a registered wake output that releases the core from the HALT state.

Parameters:
FIFO_DEPTH, 4, entries per TX and RX FIFO; power of two, >= 2
DEFAULT_DIV, 8'd3, reset value of the divisor register; bit period = DIV+1 clocks

Ports:
clock  in  1  system clock, all state on rising edge
reset  in  1  synchronous, active-high; clears all state
io_addr  in  3  I/O port select (inst[2:0])
io_load_n  in  1  active-low read strobe ("in" instruction)
io_store_n  in  1  active-low write strobe ("out" instruction)
data_in  in  8  data bus value during a store
data_out  out  8  read data; 8'h00 when io_load_n high
data_out_en  out  1  = ~io_load_n; tri-state enable for the shared data bus
rxd  in  1  asynchronous serial input, idle high
txd  out  1  serial output, idle high
wake  out  1  registered wake request to the core FSM

Behaviour:
- Register map:
  - 0 TXDATA: write pushes to TX FIFO; read returns 0x00.
  - 1 RXDATA: read returns RX head (0x00 if empty) and pops it on the clock edge.
  - 2 STATUS: read {3'b0, frame_err, overrun, rx_empty, tx_idle, tx_full}. tx_idle = TX FIFO empty and serializer IDLE. Write: bit3=1 clears overrun, bit4=1 clears frame_err.
  - 3 CONTROL (r/w, reset 0): bit0 wake_on_rx, bit1 wake_on_tx_idle; bits 7:2 read 0.
  - 4 DIV (r/w, reset DEFAULT_DIV).
  - 5-7: read 0x00, write ignored.
- Strobes are 1 clock wide. Store sampled on the edge where io_store_n=0. Read data is combinational from io_addr. Read side effects apply on the edge where io_load_n=0.
- Both strobes low in the same cycle: the store is performed; the load side effect (RX pop) is suppressed; data_out is still driven.
- Reset values: txd=1, wake=0, data_out=0x00 (strobes idle), both FIFOs empty, overrun=0, frame_err=0, TX/RX FSMs IDLE.
- TX full: a write is dropped silently. A write and a serializer pop in the same cycle with the FIFO full are both accepted.
- TX FSM (each of START/DATA/STOP bits lasts DIV+1 clocks; DIV is latched at frame start):
  - IDLE: if FIFO non-empty, pop into shift register, go to START; txd goes low on the following clock.
  - START: txd=0.
  - DATA: 8 bits, LSB first.
  - STOP: txd=1, then IDLE.
  - Back-to-back bytes: the next START begins the clock after STOP ends. No extra idle bit.
- RX path: rxd passes through a 2-flop synchronizer (2-clock latency) plus a previous-sample flop.
- RX FSM (DIV latched on start detection):
  - IDLE: on a synchronized falling edge, go to START.
  - START: wait (DIV+1)/2 clocks (integer division), resample. If high, treat as a false start and return to IDLE with no flags changed. If low, go to DATA.
  - DATA: sample every DIV+1 clocks, 8 bits, LSB first.
  - STOP: sample after a further DIV+1 clocks.
    - High: push the byte. If the FIFO is full and no pop happens that cycle, drop the byte and set overrun.
    - Low: discard the byte, set frame_err.
    - Either way return to IDLE. Edge detection resumes immediately.
  - An RX push and a CPU pop in the same cycle on a full FIFO both succeed; overrun is not set.
- Sticky flags: a hardware set has priority over a software clear in the same cycle.
- wake is registered: next wake = (wake_on_rx & ~rx_empty) | (wake_on_tx_idle & tx_idle), using current-cycle register values. It is level, not a pulse.
- Reset asserted mid-frame: txd is 1 on the next edge, the partial frame is abandoned, and the FIFO contents are lost.
- FIFO pointers are log2(FIFO_DEPTH)+1 bits and wrap modulo 2*FIFO_DEPTH. Full = MSBs differ and the low bits are equal.

Test Plan:
- TX frame: reset, write 0x5A to port 0 → txd low 4 clocks from the clock after pop, then bits 0,1,0,1,1,0,1,0 of 4 clocks each, then high 4 clocks. STATUS reads 0x02 after completion.
- Loopback txd→rxd: write 0x00, 0xFF, 0xA5 back-to-back → three consecutive RXDATA reads return 0x00, 0xFF, 0xA5. The fourth read returns 0x00 with rx_empty=1.
- Overrun: inject 5 frames with no reads, FIFO_DEPTH=4 → STATUS bit3=1, and reads return the first 4 bytes. Write 0x08 to STATUS → bit3=0.
- Framing/false start: drive an rxd low glitch of 1 clock → no push, no flags. Drive a frame with stop=0 → frame_err=1, rx_empty stays 1.
- Wake: CONTROL=0x01 while halted; after a received byte completes → wake=1 one clock after the push. Read RXDATA → wake=0 one clock after the pop.
- TX full + DIV: write DIV=0 (1 clock/bit), then write 6 bytes while busy → tx_full=1, and exactly 5 bytes are transmitted (4 in the FIFO plus 1 in the shifter). Reset asserted mid-frame → txd=1 next edge and STATUS=0x06.

Source files
------------

// File: rtl/k12a_uart_io.sv
// k12a I/O-bus responder: 8N1 UART with TX/RX FIFOs, status/control/divisor
// registers and a registered wake level that releases the core from HALT.
module k12a_uart_io #(
  parameter int          FIFO_DEPTH  = 4,
  parameter logic [7:0]  DEFAULT_DIV = 8'd3
) (
  input  logic       clock,
  input  logic       reset,
  input  logic [2:0] io_addr,
  input  logic       io_load_n,
  input  logic       io_store_n,
  input  logic [7:0] data_in,
  output logic [7:0] data_out,
  output logic       data_out_en,
  input  logic       rxd,
  output logic       txd,
  output logic       wake,
  output logic [1:0] o_dbg_tx_state,
  output logic [1:0] o_dbg_rx_state
);

  localparam int AW = $clog2(FIFO_DEPTH);

  typedef enum logic [1:0] {ST_IDLE, ST_START, ST_DATA, ST_STOP} uart_state_t;

  // Bus protocol: each strobe is a one-cycle request that is always accepted
  // (no back-pressure). A store wins over a simultaneous load's pop.
  logic w_store, w_load;
  logic w_wr_tx, w_wr_stat, w_wr_ctrl, w_wr_div;
  assign w_store   = ~io_store_n;
  assign w_load    = ~io_load_n & io_store_n;
  assign w_wr_tx   = w_store && (io_addr == 3'd0);
  assign w_wr_stat = w_store && (io_addr == 3'd2);
  assign w_wr_ctrl = w_store && (io_addr == 3'd3);
  assign w_wr_div  = w_store && (io_addr == 3'd4);

  logic [7:0] r_div;
  logic [1:0] r_ctrl;
  logic       r_overrun, r_frame_err, r_wake;

  // ---------------- TX path ----------------
  uart_state_t r_tx_state;
  logic [7:0]  r_tx_mem [FIFO_DEPTH];
  logic [AW:0] r_tx_wp, r_tx_rp;
  logic [7:0]  r_tx_sh, r_tx_cnt, r_tx_div;
  logic [2:0]  r_tx_bit;
  logic        r_txd;
  logic        w_tx_empty, w_tx_full, w_tx_pop, w_tx_push, w_tx_idle;

  assign w_tx_empty = (r_tx_wp == r_tx_rp);
  assign w_tx_full  = (r_tx_wp[AW] != r_tx_rp[AW]) && (r_tx_wp[AW-1:0] == r_tx_rp[AW-1:0]);
  assign w_tx_pop   = ~w_tx_empty && ((r_tx_state == ST_IDLE) ||
                      ((r_tx_state == ST_STOP) && (r_tx_cnt == r_tx_div)));
  assign w_tx_push  = w_wr_tx && (~w_tx_full || w_tx_pop);
  assign w_tx_idle  = w_tx_empty && (r_tx_state == ST_IDLE);

  always_ff @(posedge clock) begin
    if (w_tx_push) r_tx_mem[r_tx_wp[AW-1:0]] <= data_in;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_tx_state <= ST_IDLE;
      r_txd      <= 1'b1;
      r_tx_wp    <= '0;
      r_tx_rp    <= '0;
      r_tx_sh    <= 8'h00;
      r_tx_cnt   <= 8'h00;
      r_tx_div   <= 8'h00;
      r_tx_bit   <= 3'd0;
    end else begin
      if (w_tx_push) r_tx_wp <= r_tx_wp + 1'b1;
      // A pop starts a new frame, either from IDLE or straight out of STOP.
      if (w_tx_pop) begin
        r_tx_rp    <= r_tx_rp + 1'b1;
        r_tx_sh    <= r_tx_mem[r_tx_rp[AW-1:0]];
        r_tx_div   <= r_div;
        r_tx_cnt   <= 8'h00;
        r_tx_state <= ST_START;
        r_txd      <= 1'b0;
      end else begin
        case (r_tx_state)
          ST_START: begin
            if (r_tx_cnt == r_tx_div) begin
              r_tx_cnt   <= 8'h00;
              r_tx_bit   <= 3'd0;
              r_txd      <= r_tx_sh[0];
              r_tx_sh    <= {1'b0, r_tx_sh[7:1]};
              r_tx_state <= ST_DATA;
            end else begin
              r_tx_cnt <= r_tx_cnt + 8'd1;
            end
          end
          ST_DATA: begin
            if (r_tx_cnt == r_tx_div) begin
              r_tx_cnt <= 8'h00;
              if (r_tx_bit == 3'd7) begin
                r_txd      <= 1'b1;
                r_tx_state <= ST_STOP;
              end else begin
                r_tx_bit <= r_tx_bit + 3'd1;
                r_txd    <= r_tx_sh[0];
                r_tx_sh  <= {1'b0, r_tx_sh[7:1]};
              end
            end else begin
              r_tx_cnt <= r_tx_cnt + 8'd1;
            end
          end
          ST_STOP: begin
            if (r_tx_cnt == r_tx_div) r_tx_state <= ST_IDLE;
            else                      r_tx_cnt   <= r_tx_cnt + 8'd1;
          end
          default: ;
        endcase
      end
    end
  end

  // ---------------- RX path ----------------
  uart_state_t r_rx_state;
  logic [7:0]  r_rx_mem [FIFO_DEPTH];
  logic [AW:0] r_rx_wp, r_rx_rp;
  logic [7:0]  r_rx_sh, r_rx_cnt, r_rx_div;
  logic [2:0]  r_rx_bit;
  logic        r_rx_s1, r_rx_s2, r_rx_prev;
  logic        w_rx_empty, w_rx_full, w_rx_fall, w_rx_stop_ev;
  logic        w_rx_good, w_rx_bad, w_rx_pop, w_rx_push, w_ovr_set;
  logic [7:0]  w_rx_half;

  assign w_rx_empty   = (r_rx_wp == r_rx_rp);
  assign w_rx_full    = (r_rx_wp[AW] != r_rx_rp[AW]) && (r_rx_wp[AW-1:0] == r_rx_rp[AW-1:0]);
  assign w_rx_fall    = r_rx_prev & ~r_rx_s2;
  assign w_rx_half    = {1'b0, r_rx_div[7:1]} + {7'b0, r_rx_div[0]};
  assign w_rx_stop_ev = (r_rx_state == ST_STOP) && (r_rx_cnt == r_rx_div);
  assign w_rx_good    = w_rx_stop_ev & r_rx_s2;
  assign w_rx_bad     = w_rx_stop_ev & ~r_rx_s2;
  assign w_rx_pop     = w_load && (io_addr == 3'd1) && ~w_rx_empty;
  assign w_rx_push    = w_rx_good && (~w_rx_full || w_rx_pop);
  assign w_ovr_set    = w_rx_good && w_rx_full && ~w_rx_pop;

  always_ff @(posedge clock) begin
    if (w_rx_push) r_rx_mem[r_rx_wp[AW-1:0]] <= r_rx_sh;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_rx_s1    <= 1'b1;
      r_rx_s2    <= 1'b1;
      r_rx_prev  <= 1'b1;
      r_rx_state <= ST_IDLE;
      r_rx_wp    <= '0;
      r_rx_rp    <= '0;
      r_rx_sh    <= 8'h00;
      r_rx_cnt   <= 8'h00;
      r_rx_div   <= 8'h00;
      r_rx_bit   <= 3'd0;
    end else begin
      r_rx_s1   <= rxd;
      r_rx_s2   <= r_rx_s1;
      r_rx_prev <= r_rx_s2;
      if (w_rx_push) r_rx_wp <= r_rx_wp + 1'b1;
      if (w_rx_pop)  r_rx_rp <= r_rx_rp + 1'b1;
      case (r_rx_state)
        ST_IDLE: begin
          if (w_rx_fall) begin
            r_rx_state <= ST_START;
            r_rx_cnt   <= 8'h00;
            r_rx_div   <= r_div;
          end
        end
        ST_START: begin
          if (r_rx_cnt == w_rx_half) begin
            r_rx_cnt   <= 8'h00;
            r_rx_bit   <= 3'd0;
            r_rx_state <= r_rx_s2 ? ST_IDLE : ST_DATA;
          end else begin
            r_rx_cnt <= r_rx_cnt + 8'd1;
          end
        end
        ST_DATA: begin
          if (r_rx_cnt == r_rx_div) begin
            r_rx_cnt <= 8'h00;
            r_rx_sh  <= {r_rx_s2, r_rx_sh[7:1]};
            if (r_rx_bit == 3'd7) r_rx_state <= ST_STOP;
            else                  r_rx_bit   <= r_rx_bit + 3'd1;
          end else begin
            r_rx_cnt <= r_rx_cnt + 8'd1;
          end
        end
        ST_STOP: begin
          if (r_rx_cnt == r_rx_div) r_rx_state <= ST_IDLE;
          else                      r_rx_cnt   <= r_rx_cnt + 8'd1;
        end
        default: r_rx_state <= ST_IDLE;
      endcase
    end
  end

  // ---------------- registers, flags, wake ----------------
  always_ff @(posedge clock) begin
    if (reset) begin
      r_div       <= DEFAULT_DIV;
      r_ctrl      <= 2'b00;
      r_overrun   <= 1'b0;
      r_frame_err <= 1'b0;
      r_wake      <= 1'b0;
    end else begin
      // Hardware set beats a software clear in the same cycle.
      if (w_ovr_set)                     r_overrun   <= 1'b1;
      else if (w_wr_stat && data_in[3])  r_overrun   <= 1'b0;
      if (w_rx_bad)                      r_frame_err <= 1'b1;
      else if (w_wr_stat && data_in[4])  r_frame_err <= 1'b0;
      if (w_wr_ctrl) r_ctrl <= data_in[1:0];
      if (w_wr_div)  r_div  <= data_in;
      r_wake <= (r_ctrl[0] & ~w_rx_empty) | (r_ctrl[1] & w_tx_idle);
    end
  end

  always_comb begin
    data_out = 8'h00;
    if (!io_load_n) begin
      case (io_addr)
        3'd1:    data_out = w_rx_empty ? 8'h00 : r_rx_mem[r_rx_rp[AW-1:0]];
        3'd2:    data_out = {3'b000, r_frame_err, r_overrun, w_rx_empty, w_tx_idle, w_tx_full};
        3'd3:    data_out = {6'b000000, r_ctrl};
        3'd4:    data_out = r_div;
        default: data_out = 8'h00;
      endcase
    end
  end

  assign data_out_en    = ~io_load_n;
  assign txd            = r_txd;
  assign wake           = r_wake;
  assign o_dbg_tx_state = r_tx_state;
  assign o_dbg_rx_state = r_rx_state;

endmodule

// File: tb/tb_k12a_uart_io.sv
// Directed bench for k12a_uart_io: bus reads/writes, TX frame decode,
// loopback, overrun, framing, wake and reset-abort scenarios.
module tb_k12a_uart_io;

  logic       clock = 1'b0;
  logic       reset;
  logic [2:0] io_addr;
  logic       io_load_n, io_store_n;
  logic [7:0] data_in;
  logic [7:0] data_out;
  logic       data_out_en;
  logic       rxd_drv, lb;
  logic       rxd_w;
  logic       txd, wake;
  logic [1:0] dbg_tx, dbg_rx;

  int n_cmp, n_mis;
  logic [7:0] exp_q[$];
  logic [7:0] tx_q[$];
  logic [8:0] mon_q[$];
  int         mon_div = 3;
  int         mon_per;
  logic [9:0] mon_fr;
  logic       mon_ok;

  logic [7:0] d;
  logic       en;
  int         lows;

  assign rxd_w = lb ? txd : rxd_drv;

  k12a_uart_io #(.FIFO_DEPTH(4), .DEFAULT_DIV(8'd3)) dut (
    .clock(clock), .reset(reset), .io_addr(io_addr), .io_load_n(io_load_n),
    .io_store_n(io_store_n), .data_in(data_in), .data_out(data_out),
    .data_out_en(data_out_en), .rxd(rxd_w), .txd(txd), .wake(wake),
    .o_dbg_tx_state(dbg_tx), .o_dbg_rx_state(dbg_rx)
  );

  initial forever #5 clock = ~clock;

  task automatic tick(input int n);
    repeat (n) begin @(posedge clock); #1; end
  endtask

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp_v);
    n_cmp++;
    assert (obs === exp_v) else begin
      n_mis++;
      $error("FAIL %s: observed %02h expected %02h", tag, obs, exp_v);
    end
  endtask

  task automatic io_write(input logic [2:0] a, input logic [7:0] v);
    io_addr = a; data_in = v; io_store_n = 1'b0;
    tick(1);
    io_store_n = 1'b1;
  endtask

  task automatic io_read(input logic [2:0] a, output logic [7:0] v, output logic e);
    io_addr = a; io_load_n = 1'b0;
    #1;
    v = data_out; e = data_out_en;
    tick(1);
    io_load_n = 1'b1;
  endtask

  task automatic send_frame(input logic [7:0] b, input logic stop, input int div);
    rxd_drv = 1'b0; tick(div + 1);
    for (int i = 0; i < 8; i++) begin rxd_drv = b[i]; tick(div + 1); end
    rxd_drv = stop; tick(div + 1);
    rxd_drv = 1'b1;
  endtask

  // Compare n decoded txd frames against the TX expectation queue.
  task automatic expect_tx(input int n, input string tag);
    int w;
    logic [8:0] m;
    logic [7:0] e;
    w = 0;
    while (mon_q.size() < n && w < 2000) begin tick(1); w++; end
    check({tag, "_timeout"}, {7'b0, mon_q.size() >= n}, 8'h01);
    for (int i = 0; i < n; i++) begin
      if (mon_q.size() > 0 && tx_q.size() > 0) begin
        m = mon_q.pop_front();
        e = tx_q.pop_front();
        check(tag, m[7:0], e);
        check({tag, "_shape"}, {7'b0, m[8]}, 8'h01);
      end
    end
  endtask

  // txd frame monitor: every cycle of a frame must hold its bit value.
  initial begin
    forever begin
      @(posedge clock); #1;
      if (reset === 1'b0 && txd === 1'b0) begin
        mon_per = mon_div + 1;
        mon_fr  = '0;
        mon_ok  = 1'b1;
        for (int j = 0; j < 10 * mon_per; j++) begin
          if (j > 0) begin @(posedge clock); #1; end
          if (j % mon_per == 0) mon_fr[j / mon_per] = txd;
          else if (txd !== mon_fr[j / mon_per]) mon_ok = 1'b0;
        end
        if (mon_fr[0] !== 1'b0 || mon_fr[9] !== 1'b1) mon_ok = 1'b0;
        mon_q.push_back({mon_ok, mon_fr[8:1]});
      end
    end
  end

  initial begin
    n_cmp = 0; n_mis = 0;
    reset = 1'b1; io_addr = 3'd0; data_in = 8'h00;
    io_load_n = 1'b1; io_store_n = 1'b1; rxd_drv = 1'b1; lb = 1'b0;
    tick(3);
    reset = 1'b0;

    // Reset state
    check("rst_txd", {7'b0, txd}, 8'h01);
    check("rst_wake", {7'b0, wake}, 8'h00);
    check("rst_dout", data_out, 8'h00);
    check("rst_den", {7'b0, data_out_en}, 8'h00);
    check("rst_fsm", {4'b0, dbg_tx, dbg_rx}, 8'h00);
    io_read(3'd2, d, en); check("rst_status", d, 8'h06); check("rd_den", {7'b0, en}, 8'h01);
    io_read(3'd4, d, en); check("rst_div", d, 8'h03);
    io_read(3'd3, d, en); check("rst_ctrl", d, 8'h00);
    io_read(3'd0, d, en); check("rd_txdata", d, 8'h00);
    for (int a = 5; a < 8; a++) begin
      io_write(3'(a), 8'hFF);
      io_read(3'(a), d, en); check("rd_unused", d, 8'h00);
    end
    io_write(3'd3, 8'hFC);
    io_read(3'd3, d, en); check("ctrl_hi_bits", d, 8'h00);

    // Single TX frame, looped back into RX
    lb = 1'b1; tick(2);
    tx_q.push_back(8'h5A); exp_q.push_back(8'h5A);
    io_write(3'd0, 8'h5A);
    check("tx_pre_start", {7'b0, txd}, 8'h01);
    tick(1);
    check("tx_start", {7'b0, txd}, 8'h00);
    expect_tx(1, "tx_5a");
    tick(6);
    io_read(3'd2, d, en); check("status_after_tx", d, 8'h02);
    io_read(3'd1, d, en); check("rx_5a", d, exp_q.pop_front());

    // Back-to-back loopback
    tx_q.push_back(8'h00); tx_q.push_back(8'hFF); tx_q.push_back(8'hA5);
    exp_q.push_back(8'h00); exp_q.push_back(8'hFF); exp_q.push_back(8'hA5);
    io_write(3'd0, 8'h00); io_write(3'd0, 8'hFF); io_write(3'd0, 8'hA5);
    expect_tx(3, "tx_b2b");
    tick(6);
    for (int i = 0; i < 3; i++) begin
      io_read(3'd1, d, en); check("rx_b2b", d, exp_q.pop_front());
    end
    io_read(3'd1, d, en); check("rx_empty_read", d, 8'h00);
    io_read(3'd2, d, en); check("status_drained", d, 8'h06);
    lb = 1'b0; tick(2);

    // Overrun: five frames, no reads
    exp_q.push_back(8'h11); exp_q.push_back(8'h22);
    exp_q.push_back(8'h33); exp_q.push_back(8'h44);
    send_frame(8'h11, 1'b1, 3); send_frame(8'h22, 1'b1, 3); send_frame(8'h33, 1'b1, 3);
    send_frame(8'h44, 1'b1, 3); send_frame(8'h55, 1'b1, 3);
    tick(4);
    io_read(3'd2, d, en); check("status_overrun", d, 8'h0A);
    io_addr = 3'd1; data_in = 8'h99; io_store_n = 1'b0; io_load_n = 1'b0;
    #1; d = data_out;
    tick(1);
    io_store_n = 1'b1; io_load_n = 1'b1;
    check("both_strobes_data", d, exp_q[0]);
    for (int i = 0; i < 4; i++) begin
      io_read(3'd1, d, en); check("rx_ovr", d, exp_q.pop_front());
    end
    io_read(3'd2, d, en); check("status_ovr_sticky", d, 8'h0E);
    io_write(3'd2, 8'h08);
    io_read(3'd2, d, en); check("status_ovr_clr", d, 8'h06);

    // False start and framing error
    rxd_drv = 1'b0; tick(1); rxd_drv = 1'b1;
    tick(12);
    io_read(3'd2, d, en); check("status_glitch", d, 8'h06);
    send_frame(8'h3C, 1'b0, 3);
    tick(4);
    io_read(3'd2, d, en); check("status_ferr", d, 8'h16);
    io_write(3'd2, 8'h10);
    io_read(3'd2, d, en); check("status_ferr_clr", d, 8'h06);

    // Wake on RX and on TX idle
    io_write(3'd3, 8'h01);
    tick(1);
    check("wake_idle", {7'b0, wake}, 8'h00);
    exp_q.push_back(8'h77);
    send_frame(8'h77, 1'b1, 3);
    tick(1); check("wake_pre_push", {7'b0, wake}, 8'h00);
    tick(1); check("wake_at_push", {7'b0, wake}, 8'h00);
    tick(1); check("wake_set", {7'b0, wake}, 8'h01);
    io_read(3'd1, d, en); check("rx_wake_byte", d, exp_q.pop_front());
    check("wake_at_pop", {7'b0, wake}, 8'h01);
    tick(1); check("wake_clr", {7'b0, wake}, 8'h00);
    io_write(3'd3, 8'h02);
    check("wake_txi_pre", {7'b0, wake}, 8'h00);
    tick(1); check("wake_txi", {7'b0, wake}, 8'h01);
    io_read(3'd3, d, en); check("ctrl_rb", d, 8'h02);
    io_write(3'd3, 8'h00);

    // TX FIFO full at DIV=0
    mon_div = 0;
    io_write(3'd4, 8'h00);
    io_read(3'd4, d, en); check("div_rb", d, 8'h00);
    for (int i = 1; i <= 6; i++) begin
      if (i <= 5) tx_q.push_back(8'(i));
      io_write(3'd0, 8'(i));
    end
    io_read(3'd2, d, en); check("status_tx_full", d, 8'h05);
    expect_tx(5, "tx_burst");
    lows = 0;
    repeat (20) begin tick(1); if (txd !== 1'b1) lows++; end
    check("no_sixth_frame", 8'(lows), 8'h00);
    check("mon_q_empty", 8'(mon_q.size()), 8'h00);
    io_read(3'd2, d, en); check("status_burst_done", d, 8'h06);

    // Reset mid-frame
    io_write(3'd0, 8'h00); io_write(3'd0, 8'h00); io_write(3'd0, 8'h00);
    tick(3);
    check("tx_midframe", {7'b0, txd}, 8'h00);
    reset = 1'b1;
    tick(1);
    check("rst_mid_txd", {7'b0, txd}, 8'h01);
    reset = 1'b0;
    io_read(3'd2, d, en); check("rst_mid_status", d, 8'h06);
    io_read(3'd4, d, en); check("rst_mid_div", d, 8'h03);
    lows = 0;
    repeat (30) begin tick(1); if (txd !== 1'b1) lows++; end
    check("rst_fifo_lost", 8'(lows), 8'h00);
    mon_q.delete();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
